// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one memory read per instruction,
// presents it to decode, then waits for the retiring instruction's next PC.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | request valid at pc, waiting for memory to accept
// WAIT_RSP | request accepted, waiting for the read response
// HOLD     | inst/pc valid to decode, waiting for IDU_ready
// WAIT_NPC | instruction handed off, waiting for dnpc from writeback
// FAULT    | misaligned dnpc or fetch error; parked until reset
module ifu_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            IFU_valid,
    input  logic            IDU_ready,
    input  logic [XLEN-1:0] dnpc,
    input  logic            dnpc_valid,
    output logic            fetch_fault,
    output logic [31:0]     inst_count
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_WAIT_RSP = 3'd1,
        S_HOLD     = 3'd2,
        S_WAIT_NPC = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_inst;
    logic [31:0]       r_inst_count;
    logic              w_inst_load;
    logic              w_pc_load;
    logic              w_handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_inst_load) r_inst <= mem_rsp_data;
            if (w_pc_load) r_pc <= dnpc;
            if (w_handshake) r_inst_count <= r_inst_count + 32'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_inst_load  = 1'b0;
        w_pc_load    = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_req_ready) w_state_next = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        w_state_next = S_FAULT;
                    end else begin
                        w_inst_load  = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (IDU_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = S_WAIT_NPC;
                end
            end
            S_WAIT_NPC: begin
                if (dnpc_valid) begin
                    // pc takes the misaligned target too, so FAULT reports it
                    w_pc_load    = 1'b1;
                    w_state_next = (dnpc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
                end
            end
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // rst gating keeps memory from seeing a request while it is itself in reset
    assign mem_req_valid = (r_state == S_FETCH) && !rst;
    assign mem_req_addr  = r_pc;
    assign IFU_valid     = (r_state == S_HOLD);
    assign fetch_fault   = (r_state == S_FAULT);
    assign inst          = r_inst;
    assign pc            = r_pc;
    assign inst_count    = r_inst_count;

endmodule
